// File: rtl/mmio_responder_pkg.sv
// Shared constants for the MMIO responder: register offsets inside the window and CTRL bit layout.
package mmio_responder_pkg;

  localparam logic [1:0] OFS_OUT   = 2'd0;
  localparam logic [1:0] OFS_IN    = 2'd1;
  localparam logic [1:0] OFS_TIMER = 2'd2;
  localparam logic [1:0] OFS_CTRL  = 2'd3;

  localparam int unsigned TEN = 0;
  localparam int unsigned IEN = 1;
  localparam int unsigned TF  = 7;

  function automatic logic [7:0] ctrl_word(input logic tf, input logic ien, input logic ten);
    return {tf, 5'b0, ien, ten};
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Down-counting timer with prescaler, reload register and sticky expired flag (TF).
module mmio_timer #(
  parameter int unsigned TIMER_PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       enable,
  input  logic       clear,
  output logic [7:0] count,
  output logic       tf
);

  localparam int unsigned PW = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TIMER_PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    reload_q, reload_d;
  logic          tf_q, tf_d;
  logic          tick;
  logic          tf_set;

  always_comb begin
    tick     = enable && (pre_q == PRE_MAX);
    pre_d    = pre_q + 1'b1;
    count_d  = count_q;
    reload_d = reload_q;
    tf_set   = 1'b0;
    if (load || !enable || tick) begin
      pre_d = '0;
    end
    // A load overrides a coinciding tick, so it can never raise TF.
    if (load) begin
      reload_d = load_data;
      count_d  = load_data;
    end else if (tick) begin
      if (count_q == 8'd0) begin
        count_d = reload_q;
        tf_set  = 1'b1;
      end else begin
        count_d = count_q - 8'd1;
      end
    end
    tf_d = tf_q;
    if (clear) begin
      tf_d = 1'b0;
    end
    if (tf_set) begin
      tf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q    <= '0;
      count_q  <= 8'd0;
      reload_q <= 8'd0;
      tf_q     <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tf_q     <= tf_d;
    end
  end

  assign count = count_q;
  assign tf    = tf_q;

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: OUT, synchronized IN, TIMER and CTRL registers in a 4-address window.
// Timer, prescaler, CTRL and irq exist only when MMIO_TIMER_EN is defined.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter logic [3:0]  BASE_ADDR      = 4'hC,
  parameter int unsigned TIMER_PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       read,
  input  logic       write,
  input  logic [3:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       hit,
  input  logic [7:0] port_in,
  output logic [7:0] port_out,
  output logic       irq
);

  logic [1:0] ofs;
  logic       wr_hit;
  logic       rd_hit;
  logic [7:0] rd_data;
  logic [7:0] port_out_q;
  logic [7:0] data_out_q;
  logic [7:0] sync1_q, sync2_q;

  assign hit    = (read | write) & (addr[3:2] == BASE_ADDR[3:2]);
  assign ofs    = addr[1:0];
  assign wr_hit = write & hit;
  assign rd_hit = read & hit;

`ifdef MMIO_TIMER_EN
  logic       ten_q, ien_q;
  logic [7:0] count;
  logic       tf;
  logic       ctrl_wr;

  assign ctrl_wr = wr_hit && (ofs == OFS_CTRL);

  mmio_timer #(
    .TIMER_PRESCALE(TIMER_PRESCALE)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (wr_hit && (ofs == OFS_TIMER)),
    .load_data(data_in),
    .enable   (ten_q),
    .clear    (ctrl_wr && data_in[TF]),
    .count    (count),
    .tf       (tf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ten_q <= 1'b0;
      ien_q <= 1'b0;
    end else if (ctrl_wr) begin
      ten_q <= data_in[TEN];
      ien_q <= data_in[IEN];
    end
  end

  assign irq = tf & ien_q;
`else
  assign irq = 1'b0;
`endif

  // Read mux sees pre-write register values, so a same-cycle read returns the old contents.
  always_comb begin
    rd_data = 8'h00;
    unique case (ofs)
      OFS_OUT:   rd_data = port_out_q;
      OFS_IN:    rd_data = sync2_q;
`ifdef MMIO_TIMER_EN
      OFS_TIMER: rd_data = count;
      OFS_CTRL:  rd_data = ctrl_word(tf, ien_q, ten_q);
`else
      OFS_TIMER: rd_data = 8'h00;
      OFS_CTRL:  rd_data = 8'h00;
`endif
      default:   rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_out_q <= 8'h00;
      data_out_q <= 8'h00;
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
    end else begin
      sync1_q <= port_in;
      sync2_q <= sync1_q;
      if (wr_hit && (ofs == OFS_OUT)) begin
        port_out_q <= data_in;
      end
      if (rd_hit) begin
        data_out_q <= rd_data;
      end
    end
  end

  assign port_out = port_out_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: reads push expected data, a monitor compares data_out.
module tb_mmio_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       read, write;
  logic [3:0] addr;
  logic [7:0] data_in, data_out, port_in, port_out;
  logic       hit, irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  mmio_responder #(
    .BASE_ADDR     (4'hC),
    .TIMER_PRESCALE(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .hit     (hit),
    .port_in (port_in),
    .port_out(port_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one bus cycle from a negedge and returns at the next negedge.
  task automatic access(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd);
    logic exp_hit;
    read    = r;
    write   = w;
    addr    = a;
    data_in = d;
    exp_hit = (r | w) && (a[3:2] == 2'b11);
    if (r && exp_hit) exp_q.push_back(exp_rd);
    #1;
    check("hit", {7'b0, hit}, {7'b0, exp_hit});
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    access(1'b0, 1'b1, a, d, 8'h00);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e);
    access(1'b1, 1'b0, a, 8'h00, e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b0;
    #1;
    check("rst_data_out", data_out, 8'h00);
    check("rst_port_out", port_out, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: a hit read sampled at a rising edge must show its data by the next falling edge.
  initial begin
    logic pend;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      pend = read && rst && (addr[3:2] == 2'b11);
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow: got %h expected nothing", data_out);
        end else begin
          e = exp_q.pop_front();
          check("data_out", data_out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    addr    = 4'h0;
    data_in = 8'h00;
    port_in = 8'h00;
    idle(2);
    #1;
    check("reset_data_out", data_out, 8'h00);
    check("reset_port_out", port_out, 8'h00);
    check("reset_irq", {7'b0, irq}, 8'h00);
    rst = 1'b1;
    idle(1);

    wr(4'hC, 8'hA5);
    check("out_write", port_out, 8'hA5);
    rd(4'hC, 8'hA5);

    port_in = 8'h3C;
    idle(2);
    rd(4'hD, 8'h3C);
    wr(4'hD, 8'hFF);
    check("in_write_ignored", port_out, 8'hA5);
    rd(4'hC, 8'hA5);
    rd(4'hD, 8'h3C);

    wr(4'hC, 8'h11);
    access(1'b1, 1'b1, 4'hC, 8'h22, 8'h11);
    check("rw_same_cycle_port", port_out, 8'h22);
    rd(4'hC, 8'h22);

    for (int a = 0; a < 12; a++) begin
      access(1'b1, 1'b1, 4'(a), 8'h5A, 8'h00);
    end
    check("outside_port_out", port_out, 8'h22);
    check("outside_data_hold", data_out, 8'h22);
    rd(4'hD, 8'h3C);

`ifdef MMIO_TIMER_EN
    wr(4'hE, 8'd3);
    wr(4'hF, 8'h03);
    idle(15);
    #1;
    check("irq_before_expiry", {7'b0, irq}, 8'h00);
    idle(1);
    #1;
    check("irq_at_expiry", {7'b0, irq}, 8'h01);
    rd(4'hF, 8'h83);
    rd(4'hE, 8'd3);
    wr(4'hF, 8'h83);
    check("irq_cleared", {7'b0, irq}, 8'h00);
    // This load lands on a tick edge; it must win and leave TF clear.
    wr(4'hE, 8'd0);
    idle(3);
    #1;
    check("load_beats_tick", {7'b0, irq}, 8'h00);
    // Clear lands on the tick that expires count 0: set wins.
    wr(4'hF, 8'h83);
    check("set_beats_clear", {7'b0, irq}, 8'h01);
    rd(4'hF, 8'h83);
    wr(4'hF, 8'h83);
    check("irq_cleared2", {7'b0, irq}, 8'h00);
    wr(4'hE, 8'd5);
    idle(12);
    rd(4'hE, 8'd2);
    do_reset();
    rd(4'hE, 8'h00);
    rd(4'hF, 8'h00);
    rd(4'hC, 8'h00);
`else
    wr(4'hE, 8'd7);
    wr(4'hF, 8'h83);
    rd(4'hE, 8'h00);
    rd(4'hF, 8'h00);
    idle(40);
    #1;
    check("irq_tied_low", {7'b0, irq}, 8'h00);
    rd(4'hC, 8'h22);
    do_reset();
    rd(4'hC, 8'h00);
    rd(4'hF, 8'h00);
`endif

    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder on the CPU data-memory bus, next to the 16-entry data RAM. It answers CPU read and write strobes in a 4-address window with four registers: output port, synchronized input port, down-counting timer, and control/status. It drives a one-cycle-latency read bus and a window-hit flag, which the top level uses to pick between RAM data and this block's data.

## Interface
Parameters:
- BASE_ADDR, 4'hC: window base; must be a multiple of 4; window is BASE_ADDR..BASE_ADDR+3
- TIMER_PRESCALE, 4: clock cycles per timer tick, legal range 1..256

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- read  input  1  CPU data-memory read strobe
- write  input  1  CPU data-memory write strobe
- addr  input  4  CPU data-memory address
- data_in  input  8  CPU write data (accumulator)
- data_out  output  8  registered read data
- hit  output  1  combinational: (read|write) & addr[3:2]==BASE_ADDR[3:2]
- port_in  input  8  external asynchronous input pins
- port_out  output  8  output port register
- irq  output  1  timer interrupt request, level

## Operation
- Offset = addr[1:0] inside the window. Strobes with hit=0 are ignored.
- Offset 0, OUT (RW): write loads port_out; read returns port_out.
- Offset 1, IN (RO): read returns port_in after a 2-flop synchronizer; writes ignored.
- Offset 2, TIMER (RW):
  - Write loads reload, loads count, and clears the prescaler.
  - Read returns the live count.
- Offset 3, CTRL (RW):
  - bit0 = TEN (timer enable), bit1 = IEN (interrupt enable), bit7 = TF (expired flag).
  - Write sets TEN and IEN from data_in bits 0 and 1. Writing 1 to bit7 clears TF.
  - Read returns {TF,5'b0,IEN,TEN}.
- Prescaler:
  - Counts 0..TIMER_PRESCALE-1 while TEN=1. Tick = prescaler at TIMER_PRESCALE-1 and TEN=1.
  - Held at 0 while TEN=0.
- On a tick: if count==0, count<=reload and TF<=1; otherwise count<=count-1.
- irq = TF & IEN.
- Read and write in the same cycle to the same offset: the write commits and data_out returns the pre-write value.
- TF set by a tick and cleared by a write in the same cycle: set wins, TF=1.
- A TIMER write in the same cycle as a tick: the write wins and no TF is set.
- reload=0 with TEN=1: TF is set on every tick.
- Reset:
  - port_out=0, data_out=0, count=0, reload=0, prescaler=0, TEN=IEN=TF=0, irq=0, synchronizer flops=0.
  - Asserting rst mid-count returns all of these to reset values immediately.

## Timing
- Write: committed at the rising edge where write & hit. port_out is visible the following cycle.
- Read: data_out is updated at the edge where read & hit, so the value is valid 1 cycle after the strobe, the same as the RAM. data_out holds its value when there is no hit read.
- hit is combinational from addr, read and write, with no latency.
- port_in to IN readback: 2 synchronizer cycles, plus 1 read cycle.
- Timer period = (reload+1) × TIMER_PRESCALE cycles between TF sets.
- irq asserts the cycle after the tick that sets TF.

## Configuration
- MMIO_TIMER_EN defined: the timer, prescaler, TF, IEN and irq are as specified above.
- MMIO_TIMER_EN undefined:
  - TIMER and CTRL read 8'h00, and writes to them are ignored.
  - irq is tied to 0.
  - No timer or prescaler flops are synthesized.

## Structure
- Shared package holds:
  - offset constants: OFS_OUT=2'd0, OFS_IN=2'd1, OFS_TIMER=2'd2, OFS_CTRL=2'd3
  - CTRL bit indices: TEN=0, IEN=1, TF=7
- One sub-module, mmio_timer: prescaler, count, reload and TF logic. Its inputs are load, load data, enable and clear; its outputs are count and TF.
- The top-level data mux selects this block's data_out when hit was registered on the previous cycle, otherwise RAM data.

## Test plan
- Reset, then write 8'hA5 to 4'hC → port_out=8'hA5 the next cycle; read 4'hC → data_out=8'hA5 one cycle later.
- Drive port_in=8'h3C, wait 2 cycles, read 4'hD → data_out=8'h3C. Write 4'hD → no register change.
- With TIMER_PRESCALE=4: write TIMER=3, then CTRL=8'h03 → TF and irq set after 16 cycles, count reloads to 3. Write CTRL=8'h83 → TF=0, irq=0.
- Arrange a tick that sets TF in the same cycle as a CTRL write of 8'h83 → TF stays 1.
- Read and write OUT in the same cycle with old value 8'h11 and new value 8'h22 → data_out=8'h11, port_out=8'h22.
- Accesses to 4'h0–4'hB → hit=0 and no state change.
- Assert rst while count=2 → all outputs 0. Build without MMIO_TIMER_EN → TIMER and CTRL read 8'h00, irq stays 0.
